// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with per-digit blanking gap,
// frame-level input snapshot and fully registered outputs.
module seven_segment_scanner #(
  parameter int w_digit      = 4,
  parameter int digit_cycles = 12500,
  parameter int blank_cycles = 250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     enable,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_start
);

  localparam int M1 =
    (digit_cycles > blank_cycles) ? digit_cycles : blank_cycles;
  localparam int MC = (M1 > 2) ? M1 : 2;
  localparam int CW = $clog2(MC);
  localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [CW-1:0] D_LAST = CW'(digit_cycles - 1);
  localparam logic [CW-1:0] B_LAST =
    CW'((blank_cycles > 0) ? blank_cycles - 1 : 0);
  localparam logic [IW-1:0] I_LAST = IW'(w_digit - 1);
  localparam logic [w_digit-1:0] ONE = w_digit'(1);

  typedef enum logic {BLANK, SHOW} state_t;

  // Each slot opens with a gap unless the gap is configured away.
  localparam state_t SLOT_START = (blank_cycles == 0) ? SHOW : BLANK;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [4*w_digit-1:0] snap_num;
  logic [w_digit-1:0]   snap_dot;
  logic [w_digit-1:0]   snap_en;

  logic                 first;
  logic [4*w_digit-1:0] num_v;
  logic [w_digit-1:0]   dot_v;
  logic [w_digit-1:0]   en_v;
  logic [3:0]           nib;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] g;
    unique case (n)
      4'h0: g = 8'hFC;
      4'h1: g = 8'h60;
      4'h2: g = 8'hDA;
      4'h3: g = 8'hF2;
      4'h4: g = 8'h66;
      4'h5: g = 8'hB6;
      4'h6: g = 8'hBE;
      4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;
      4'h9: g = 8'hF6;
      4'hA: g = 8'hEE;
      4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;
      4'hD: g = 8'h7A;
      4'hE: g = 8'h9E;
      4'hF: g = 8'h8E;
    endcase
    return g;
  endfunction

  // On the capture cycle the fresh inputs are what the frame shows.
  always_comb begin
    first = (idx == '0) && (cnt == '0) && (state == SLOT_START);
    num_v = first ? number : snap_num;
    dot_v = first ? dots   : snap_dot;
    en_v  = first ? enable : snap_en;
    nib   = num_v[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SLOT_START;
      cnt         <= '0;
      idx         <= '0;
      snap_num    <= '0;
      snap_dot    <= '0;
      snap_en     <= '0;
      abcdefgh    <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= first;
      if (first) begin
        snap_num <= number;
        snap_dot <= dots;
        snap_en  <= enable;
      end
      if (state == SHOW && en_v[idx]) begin
        digit    <= ONE << idx;
        abcdefgh <= glyph(nib) | {7'b0, dot_v[idx]};
      end else begin
        digit    <= '0;
        abcdefgh <= '0;
      end
      unique case (state)
        BLANK: begin
          if (cnt == B_LAST) begin
            state <= SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == D_LAST) begin
            state <= SLOT_START;
            cnt   <= '0;
            idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter w_digit, default 4: number of multiplexed digits sharing one segment bus.
REQ-002 SHALL have parameter digit_cycles, default 12500: clk cycles each digit is driven, legal range >= 1.
REQ-003 SHALL have parameter blank_cycles, default 250: anti-ghosting gap before each digit, legal range >= 0.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port number  input  4*w_digit  hex nibbles; nibble i, bits [4i+3:4i], is shown on digit i.
REQ-007 SHALL have port dots  input  w_digit  decimal point request per digit.
REQ-008 SHALL have port enable  input  w_digit  per-digit enable; 0 darkens that digit.
REQ-009 SHALL have port abcdefgh  output  8  active-high segments: bit7=a ... bit1=g, bit0=h (dot).
REQ-010 SHALL have port digit  output  w_digit  active-high one-hot digit select, with digit[i] selecting digit i.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-012 SHALL implement states BLANK and SHOW, a cycle counter, and a digit index idx in the range 0..w_digit-1.
REQ-013 SHALL keep BLANK for exactly blank_cycles cycles, with digit=0 and abcdefgh=0.
REQ-014 SHALL go BLANK -> SHOW after the last BLANK cycle.
REQ-015 SHALL keep SHOW for exactly digit_cycles cycles, then go SHOW -> BLANK, with idx incrementing and wrapping from w_digit-1 to 0.
REQ-016 SHALL skip BLANK entirely when blank_cycles=0, so SHOW follows SHOW and idx advances every digit_cycles.
REQ-017 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-018 SHALL, in SHOW with snapshot enable[idx]=1, drive digit one-hot at idx, abcdefgh[7:1]=glyph(snapshot nibble idx) and abcdefgh[0]=snapshot dots[idx].
REQ-019 SHALL, in SHOW with snapshot enable[idx]=0, drive digit=0 and abcdefgh=0 while keeping the slot length unchanged, so frame timing is independent of enable.
REQ-020 SHALL use this glyph table, hex digit -> abcdefgh with h=0: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E.
REQ-021 SHALL capture number, dots and enable into snapshot registers on the first cycle of every frame, where the first cycle of a frame is the first cycle of idx=0 (BLANK, or SHOW when blank_cycles=0).
REQ-022 SHALL display only snapshot values, so input changes mid-frame take effect at the next frame.
REQ-023 SHALL assert frame_start for exactly the one cycle in which the snapshot is captured.
REQ-024 SHALL have frame period w_digit*(blank_cycles+digit_cycles) cycles, and SHALL never have more than one digit bit high.
REQ-025 SHALL size the counter to ceil(log2(max(digit_cycles,blank_cycles,2))) bits, and the counter SHALL never exceed its limit.

Reset
REQ-026 SHALL, while rst=0, immediately and without a clock edge force abcdefgh=0, digit=0, frame_start=0, idx=0, counter=0 and snapshots=0, with state=BLANK (or SHOW when blank_cycles=0).
REQ-027 SHALL treat the first clk edge after rst rises as the first cycle of a frame (snapshot capture, frame_start=1).
REQ-028 SHALL, on reset asserted mid-operation, abandon the current slot and restart from idx 0 after release.

Verification (w_digit=4, digit_cycles=4, blank_cycles=2 unless stated)
REQ-029 SHALL verify release from reset with number=16'h3210, dots=0, enable=F: frame_start=1 on cycle 0; digit=0 for cycles 0-1; digit=0001 and abcdefgh=FC for cycles 2-5.
REQ-030 SHALL verify a full frame with the same stimulus: digit 0010/60, then 0100/DA, then 1000/F2, each for 4 cycles after a 2-cycle blank; frame_start recurs every 24 cycles.
REQ-031 SHALL verify mid-frame update: number changed to 16'hFFFF at cycle 8 leaves digits 1-3 showing 60/DA/F2 in the current frame, and all digits show 8E from the next frame.
REQ-032 SHALL verify masking: enable=4'b1011, dots=4'b0001 gives digit 0 abcdefgh=FD, digit 2's slot all-zero for 4 cycles, and the frame still lasts 24 cycles.
REQ-033 SHALL verify asynchronous reset: rst=0 applied mid-SHOW between clk edges drives digit=0 and abcdefgh=0 before the next edge.
REQ-034 SHALL verify the no-blank configuration: with blank_cycles=0 digit is never 0, each digit lasts 4 cycles, and the frame period is 16.
